// File: rtl/touch_key_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : touch_pkg
//  Description : Shared types and defaults for the touch-pad input conditioning
//                path (FSM state encoding, debounce/long-press defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package touch_pkg;

    localparam int unsigned CLK_FREQ_HZ           = 50_000_000;
    // 20 ms of stable input at 50 MHz
    localparam int unsigned TOUCH_DEB_CYCLES_DEF  = 1_000_000;
    // 1 s hold at 50 MHz
    localparam int unsigned TOUCH_LONG_CYCLES_DEF = 50_000_000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } touch_state_t;

endpackage
`default_nettype wire

// File: rtl/touch_key_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : touch_key_filter_if
//  Description : Raw touch-pad input and the conditioned key outputs.
//                slave  = the filter (consumes touch_key, drives key_*)
//                master = the pad/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface touch_key_filter_if;

    logic touch_key;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    modport slave (
        input  touch_key,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );

    modport master (
        output touch_key,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

endinterface
`default_nettype wire

// File: rtl/touch_key_filter_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchroniser for asynchronous pin inputs,
//                synchronous active-high reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/touch_key_filter.sv
`default_nettype none
// ============================================================================
//  Module      : touch_key_filter
//  Description : Synchronises the raw touch-pad pin, debounces press and
//                release, and produces a clean level plus one-cycle press,
//                release and long-press strobes. All outputs are registered.
//  Config      : TOUCH_LONG_PRESS_EN - when defined, the long-press counter
//                and key_long strobe are built; otherwise key_long is tied 0
//                and LONG_CYCLES is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_key_filter
    import touch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = TOUCH_DEB_CYCLES_DEF,   // >= 2
    parameter int unsigned LONG_CYCLES = TOUCH_LONG_CYCLES_DEF   // > DEB_CYCLES
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    touch_key_filter_if.slave  key_if
);

    localparam int unsigned        DEB_W    = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             key_sync;
    touch_state_t     state_q,   state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    sync_2ff u_sync (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (key_if.touch_key),
        .q_o   (key_sync)
    );

    // Debounce FSM: next state, debounce counter, level and press/release strobes
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d   = PRESS_DEB;
                    deb_cnt_d = '0;
                end
            end
            PRESS_DEB: begin
                if (!key_sync) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_d   = RELEASE_DEB;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_DEB: begin
                if (key_sync) begin
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Debounce FSM state and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_if.key_level   = level_q;
    assign key_if.key_press   = press_q;
    assign key_if.key_release = release_q;

`ifdef TOUCH_LONG_PRESS_EN
    localparam int unsigned       LONG_W    = $clog2(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt_q,  long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_q,      long_d;

    // Hold timer: restarts on an accepted press and keeps running through
    // release bounce so a glitch does not restart long-press timing
    always_comb begin
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (press_d) begin
            long_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if ((state_q == HELD) || (state_q == RELEASE_DEB)) begin
            if (long_cnt_q == LONG_LAST) begin
                if (!long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
            end else begin
                long_cnt_d = long_cnt_q + LONG_W'(1);
            end
        end
    end

    // Hold timer registers and long-press strobe
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    assign key_if.key_long = long_q;
`else
    // Long-press path not built; parameter kept only for interface stability
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_CYCLES > DEB_CYCLES);
    assign key_if.key_long = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_touch_key_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_touch_key_filter
//  Description : Directed self-checking bench for touch_key_filter with
//                DEB_CYCLES=4, LONG_CYCLES=16. Long-press expectations follow
//                TOUCH_LONG_PRESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_touch_key_filter;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 16;
    // With inputs changed just after edge e, edge e+1 is the first sample;
    // the press/release strobe appears after step number DEB+3.
    localparam int STROBE_STEP = DEB + 3;

`ifdef TOUCH_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic sys_clk;
    logic sys_rst;
    int   checks;
    int   errors;

    touch_key_filter_if key_if ();

    touch_key_filter #(
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_if  (key_if)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // One active edge, then settle away from it
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        key_if.touch_key = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
        checks++;
        if (key_if.key_level !== 1'b0) begin
            errors++; $display("FAIL reset_level got %b want 0", key_if.key_level);
        end
        checks++;
        if (key_if.key_press !== 1'b0) begin
            errors++; $display("FAIL reset_press got %b want 0", key_if.key_press);
        end
        checks++;
        if (key_if.key_release !== 1'b0) begin
            errors++; $display("FAIL reset_release got %b want 0", key_if.key_release);
        end
        checks++;
        if (key_if.key_long !== 1'b0) begin
            errors++; $display("FAIL reset_long got %b want 0", key_if.key_long);
        end
        step();
        step();
    endtask

    // Press from idle; leaves the key held
    task automatic test_clean_press();
        key_if.touch_key = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            checks++;
            if (key_if.key_press !== (j == STROBE_STEP)) begin
                errors++; $display("FAIL clean_press step %0d got %b want %b", j, key_if.key_press, (j == STROBE_STEP));
            end
            checks++;
            if (key_if.key_level !== (j >= STROBE_STEP)) begin
                errors++; $display("FAIL clean_level step %0d got %b want %b", j, key_if.key_level, (j >= STROBE_STEP));
            end
        end
    endtask

    // From HELD: 2-cycle drop is rejected, then a long low is accepted
    task automatic test_release_bounce();
        key_if.touch_key = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j == 2) key_if.touch_key = 1'b1;
            checks++;
            if (key_if.key_release !== 1'b0 || key_if.key_level !== 1'b1) begin
                errors++; $display("FAIL bounce step %0d got rel=%b lvl=%b want rel=0 lvl=1", j, key_if.key_release, key_if.key_level);
            end
        end
        key_if.touch_key = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            checks++;
            if (key_if.key_release !== (j == STROBE_STEP)) begin
                errors++; $display("FAIL release step %0d got %b want %b", j, key_if.key_release, (j == STROBE_STEP));
            end
            checks++;
            if (key_if.key_level !== (j < STROBE_STEP)) begin
                errors++; $display("FAIL release_level step %0d got %b want %b", j, key_if.key_level, (j < STROBE_STEP));
            end
        end
    endtask

    // 3-cycle pulse is shorter than the debounce window
    task automatic test_glitch();
        key_if.touch_key = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            step();
            if (j == 3) key_if.touch_key = 1'b0;
            checks++;
            if (key_if.key_press !== 1'b0 || key_if.key_level !== 1'b0 || key_if.key_release !== 1'b0) begin
                errors++; $display("FAIL glitch step %0d got press=%b lvl=%b rel=%b want 0 0 0", j, key_if.key_press, key_if.key_level, key_if.key_release);
            end
        end
    endtask

    // 40-cycle hold: one long strobe LONG edges after the press edge
    task automatic test_long_press();
        int longs;
        longs = 0;
        key_if.touch_key = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (key_if.key_long === 1'b1) longs++;
            checks++;
            if (key_if.key_long !== (LONG_EN && (j == STROBE_STEP + LONG))) begin
                errors++; $display("FAIL long step %0d got %b want %b", j, key_if.key_long, (LONG_EN && (j == STROBE_STEP + LONG)));
            end
        end
        key_if.touch_key = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (key_if.key_long === 1'b1) longs++;
        end
        checks++;
        if (longs != (LONG_EN ? 1 : 0)) begin
            errors++; $display("FAIL long_count got %0d want %0d", longs, (LONG_EN ? 1 : 0));
        end
        checks++;
        if (key_if.key_level !== 1'b0) begin
            errors++; $display("FAIL long_released_level got %b want 0", key_if.key_level);
        end
    endtask

    // Release accepted before LONG cycles: no long strobe at all
    task automatic test_short_hold();
        int longs;
        int presses;
        int releases;
        longs = 0; presses = 0; releases = 0;
        key_if.touch_key = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            step();
            if (j == STROBE_STEP + 1) key_if.touch_key = 1'b0;
            if (key_if.key_long === 1'b1) longs++;
            if (key_if.key_press === 1'b1) presses++;
            if (key_if.key_release === 1'b1) releases++;
        end
        checks++;
        if (longs != 0) begin
            errors++; $display("FAIL short_long got %0d want 0", longs);
        end
        checks++;
        if (presses != 1 || releases != 1) begin
            errors++; $display("FAIL short_strobes got press=%0d rel=%0d want 1 1", presses, releases);
        end
    endtask

    // Reset while HELD clears outputs without a release; held key re-presses
    task automatic test_reset_mid_hold();
        int releases;
        releases = 0;
        key_if.touch_key = 1'b1;
        for (int j = 1; j <= 10; j++) step();
        checks++;
        if (key_if.key_level !== 1'b1) begin
            errors++; $display("FAIL pre_reset_level got %b want 1", key_if.key_level);
        end
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        checks++;
        if ({key_if.key_level, key_if.key_press, key_if.key_release, key_if.key_long} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_outputs got %b%b%b%b want 0000", key_if.key_level, key_if.key_press, key_if.key_release, key_if.key_long);
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            if (key_if.key_release === 1'b1) releases++;
            checks++;
            if (key_if.key_press !== (j == STROBE_STEP)) begin
                errors++; $display("FAIL post_reset_press step %0d got %b want %b", j, key_if.key_press, (j == STROBE_STEP));
            end
        end
        checks++;
        if (releases != 0) begin
            errors++; $display("FAIL post_reset_release got %0d want 0", releases);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sys_rst = 1'b1;
        key_if.touch_key = 1'b0;
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_glitch();
        test_long_press();
        test_short_hold();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/touch_key_filter.md
# touch_key_filter

Conditions the raw capacitive touch-pad input before it reaches the LED toggle logic. It synchronises the pin, rejects bounce and glitches with a debounce state machine, and emits a clean level plus single-cycle press, release and long-press strobes. The downstream touch_led stage consumes `key_level` as its `touch_key` input, or `key_press` directly.

## Interface
- `DEB_CYCLES`, default 1_000_000: stable cycles required to accept a press or a release (20 ms at 50 MHz); must be ≥ 2.
- `LONG_CYCLES`, default 50_000_000: cycles in HELD before the long-press strobe fires (1 s); must be > `DEB_CYCLES`.
- `sys_clk` input, 1 bit: system clock, 50 MHz.
- `sys_rst` input, 1 bit: one clock; reset is synchronous and active-high.
- `touch_key` input, 1 bit: raw asynchronous touch-pad output, high = touched.
- `key_level` output, 1 bit: debounced touch state.
- `key_press` output, 1 bit: one-cycle strobe when a press is accepted.
- `key_release` output, 1 bit: one-cycle strobe when a release is accepted.
- `key_long` output, 1 bit: one-cycle strobe when a hold reaches `LONG_CYCLES`.

## Operation
- `touch_key` passes through a 2-FF synchroniser (reset 0), giving `key_sync`. All later logic uses only `key_sync`.
- FSM states, reset state IDLE:
  - IDLE: if `key_sync`=1, go to PRESS_DEB and set `deb_cnt`=0.
  - PRESS_DEB:
    - `key_sync`=0: go to IDLE (bounce rejected, no strobe).
    - `key_sync`=1 and `deb_cnt`=`DEB_CYCLES`-1: go to HELD, set `key_level`=1, pulse `key_press`, clear `long_cnt` and `long_done`.
    - Otherwise increment `deb_cnt`.
  - HELD:
    - `long_cnt` increments and saturates at `LONG_CYCLES`-1.
    - When it first reaches `LONG_CYCLES`-1 with `long_done`=0, pulse `key_long` and set `long_done`.
    - `key_sync`=0: go to RELEASE_DEB and set `deb_cnt`=0.
  - RELEASE_DEB:
    - `long_cnt` keeps counting.
    - `key_sync`=1: return to HELD. `long_cnt` and `long_done` are kept, so a release glitch does not restart the long-press timing.
    - `key_sync`=0 and `deb_cnt`=`DEB_CYCLES`-1: go to IDLE, set `key_level`=0, pulse `key_release`.
    - Otherwise increment `deb_cnt`.
- Counter widths:
  - `deb_cnt` is $clog2(`DEB_CYCLES`) bits.
  - `long_cnt` is $clog2(`LONG_CYCLES`) bits.
  - Neither counter wraps.
- At most one strobe per cycle except `key_long` with HELD self-loop; `key_press`/`key_release` are mutually exclusive by construction.
- A held key produces exactly one `key_long` per press.

## Timing
- Reset values:
  - Outputs: `key_level`=0, `key_press`=0, `key_release`=0, `key_long`=0.
  - Internal: FSM=IDLE, synchroniser=0, both counters=0, `long_done`=0.
- All outputs are registered.
- If `touch_key` is first sampled high at edge k and stays high, FSM enters PRESS_DEB at edge k+2, and `key_press`/`key_level` rise at edge k+2+`DEB_CYCLES`.
- Release latency is symmetric: `key_release` and the `key_level` fall occur at edge k+2+`DEB_CYCLES` after the first low sample.
- `key_long` is high for the cycle following edge (press edge + `LONG_CYCLES`), provided the key is still HELD or in RELEASE_DEB.
- If a release is accepted before `LONG_CYCLES` is reached, no `key_long` is produced.
- `sys_rst` asserted mid-press: the next edge returns everything to reset values. No release strobe is emitted.
- Strobes last exactly one cycle regardless of input.

## Configuration
- `TOUCH_LONG_PRESS_EN` defined: `long_cnt`, `long_done` and `key_long` behave as above.
- Not defined: the long-press logic is removed, `key_long` is tied to 0, and the `LONG_CYCLES` parameter is kept but ignored.

## Structure
- Shared package `touch_pkg`:
  - FSM state enum `touch_state_t` (IDLE, PRESS_DEB, HELD, RELEASE_DEB).
  - Default constants `TOUCH_DEB_CYCLES_DEF` and `TOUCH_LONG_CYCLES_DEF`.
  - `CLK_FREQ_HZ` = 50_000_000.
- One sub-module, `sync_2ff`: a 1-bit, two-flop synchroniser with synchronous active-high reset to 0. It is reused by other pin inputs.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `LONG_CYCLES`=16; scenario 4 additionally has `TOUCH_LONG_PRESS_EN` defined.
1. Clean press: `touch_key` 0→1 at edge 10 and held → `key_press` high for one cycle after edge 16, `key_level`=1 from edge 16.
2. Glitch: `touch_key` high for 3 cycles then low → no strobes, `key_level` stays 0, FSM returns to IDLE.
3. Release bounce: while HELD, drop the input for 2 cycles then raise it → no `key_release`, `key_level` stays 1; a later 10-cycle low gives one `key_release` 6 edges after the first low sample.
4. Long press: hold for 40 cycles → exactly one `key_long`, 16 edges after the `key_press` edge; recompile without the macro → `key_long` is never 1.
5. Reset mid-hold: assert `sys_rst` for 1 cycle while HELD → all outputs 0 on the next edge and no `key_release`; keeping the input high gives a fresh `key_press` 6 edges after the first high sample after reset is released.
